// File: rtl/ddr3_init_seq_if.sv
// Configuration command port between the DDR3 init sequencer and ddr3_fsm.
interface ddr3_init_seq_if #(
  parameter int ROW_BITS = 13
);
  logic                cfg_req_o;
  logic                cfg_rdy_i;
  logic [2:0]          cfg_cmd_o;
  logic [2:0]          cfg_ba_o;
  logic [ROW_BITS-1:0] cfg_adr_o;
  logic                cfg_run_o;

  modport master (output cfg_req_o, cfg_cmd_o, cfg_ba_o, cfg_adr_o, cfg_run_o,
                  input  cfg_rdy_i);
  modport slave  (input  cfg_req_o, cfg_cmd_o, cfg_ba_o, cfg_adr_o, cfg_run_o,
                  output cfg_rdy_i);
endinterface

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: RESET#/CKE timing, MR2/MR3/MR1/MR0 via req/rdy, then run.
// Define DDR3_INIT_ZQCL_EN to add a ZQCL plus tZQinit wait before run.
module ddr3_init_seq #(
  parameter int DDR_FREQ_MHZ = 100,
  parameter int DDR_ROW_BITS = 13,
  parameter int RESET_US     = 200,
  parameter int CKE_US       = 500,
  parameter int TXPR_CYCLES  = 12,
  parameter int TMRD_CYCLES  = 4,
  parameter int TMOD_CYCLES  = 12,
  parameter logic [DDR_ROW_BITS-1:0] MR0_VAL = DDR_ROW_BITS'('h0520),
  parameter logic [DDR_ROW_BITS-1:0] MR1_VAL = DDR_ROW_BITS'('h0004),
  parameter logic [DDR_ROW_BITS-1:0] MR2_VAL = DDR_ROW_BITS'('h0000),
  parameter logic [DDR_ROW_BITS-1:0] MR3_VAL = DDR_ROW_BITS'('h0000)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             dfi_rst_no,
  output logic             dfi_cke_o,
  ddr3_init_seq_if.master  cfg
);
  localparam int RST_CYC = RESET_US * DDR_FREQ_MHZ;
  localparam int CKE_CYC = CKE_US * DDR_FREQ_MHZ;
  localparam int MAX_A   = (CKE_CYC > RST_CYC) ? CKE_CYC : RST_CYC;
  localparam int MAX_B   = (TXPR_CYCLES > TMOD_CYCLES) ? TXPR_CYCLES : TMOD_CYCLES;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
`ifdef DDR3_INIT_ZQCL_EN
  localparam int TZQ_CYC = 512;
  localparam int CNT_MAX = (MAX_C > TZQ_CYC) ? MAX_C : TZQ_CYC;
  localparam logic [DDR_ROW_BITS-1:0] ZQ_ADR = DDR_ROW_BITS'(1) << 10;
`else
  localparam int CNT_MAX = MAX_C;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_ZQCL = 3'b110;
  localparam logic [2:0] CMD_NOP  = 3'b111;

`ifdef DDR3_INIT_ZQCL_EN
  typedef enum logic [3:0] {
    ST_RST, ST_CKE, ST_TXPR, ST_MR2, ST_W2, ST_MR3, ST_W3,
    ST_MR1, ST_W1, ST_MR0, ST_TMOD, ST_ZQ, ST_TZQ, ST_RUN
  } state_t;
`else
  typedef enum logic [3:0] {
    ST_RST, ST_CKE, ST_TXPR, ST_MR2, ST_W2, ST_MR3, ST_W3,
    ST_MR1, ST_W1, ST_MR0, ST_TMOD, ST_RUN
  } state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;

  // Every wait loads N-1 on entry so the state lasts exactly N cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_RST;
      cnt            <= CW'(RST_CYC - 1);
      dfi_rst_no     <= 1'b0;
      dfi_cke_o      <= 1'b0;
      cfg.cfg_req_o  <= 1'b0;
      cfg.cfg_cmd_o  <= CMD_NOP;
      cfg.cfg_ba_o   <= 3'd0;
      cfg.cfg_adr_o  <= '0;
      cfg.cfg_run_o  <= 1'b0;
    end else begin
      case (state)
        ST_RST:
          if (cnt == '0) begin
            state      <= ST_CKE;
            cnt        <= CW'(CKE_CYC - 1);
            dfi_rst_no <= 1'b1;
          end else cnt <= cnt - 1'b1;
        ST_CKE:
          if (cnt == '0) begin
            state     <= ST_TXPR;
            cnt       <= CW'(TXPR_CYCLES - 1);
            dfi_cke_o <= 1'b1;
          end else cnt <= cnt - 1'b1;
        ST_TXPR:
          if (cnt == '0) begin
            state         <= ST_MR2;
            cfg.cfg_req_o <= 1'b1;
            cfg.cfg_cmd_o <= CMD_MRS;
            cfg.cfg_ba_o  <= 3'd2;
            cfg.cfg_adr_o <= MR2_VAL;
          end else cnt <= cnt - 1'b1;
        ST_W2:
          if (cnt == '0) begin
            state         <= ST_MR3;
            cfg.cfg_req_o <= 1'b1;
            cfg.cfg_cmd_o <= CMD_MRS;
            cfg.cfg_ba_o  <= 3'd3;
            cfg.cfg_adr_o <= MR3_VAL;
          end else cnt <= cnt - 1'b1;
        ST_W3:
          if (cnt == '0) begin
            state         <= ST_MR1;
            cfg.cfg_req_o <= 1'b1;
            cfg.cfg_cmd_o <= CMD_MRS;
            cfg.cfg_ba_o  <= 3'd1;
            cfg.cfg_adr_o <= MR1_VAL;
          end else cnt <= cnt - 1'b1;
        ST_W1:
          if (cnt == '0) begin
            state         <= ST_MR0;
            cfg.cfg_req_o <= 1'b1;
            cfg.cfg_cmd_o <= CMD_MRS;
            cfg.cfg_ba_o  <= 3'd0;
            cfg.cfg_adr_o <= MR0_VAL;
          end else cnt <= cnt - 1'b1;
        // Request phases: req is high here, so rdy alone marks the transfer.
        ST_MR2, ST_MR3, ST_MR1, ST_MR0:
          if (cfg.cfg_rdy_i) begin
            cfg.cfg_req_o <= 1'b0;
            cfg.cfg_cmd_o <= CMD_NOP;
            case (state)
              ST_MR2:  state <= ST_W2;
              ST_MR3:  state <= ST_W3;
              ST_MR1:  state <= ST_W1;
              default: state <= ST_TMOD;
            endcase
            cnt <= (state == ST_MR0) ? CW'(TMOD_CYCLES - 1) : CW'(TMRD_CYCLES - 1);
          end
`ifdef DDR3_INIT_ZQCL_EN
        ST_TMOD:
          if (cnt == '0) begin
            state         <= ST_ZQ;
            cfg.cfg_req_o <= 1'b1;
            cfg.cfg_cmd_o <= CMD_ZQCL;
            cfg.cfg_ba_o  <= 3'd0;
            cfg.cfg_adr_o <= ZQ_ADR;
          end else cnt <= cnt - 1'b1;
        ST_ZQ:
          if (cfg.cfg_rdy_i) begin
            state         <= ST_TZQ;
            cnt           <= CW'(TZQ_CYC - 1);
            cfg.cfg_req_o <= 1'b0;
            cfg.cfg_cmd_o <= CMD_NOP;
          end
        ST_TZQ:
          if (cnt == '0) begin
            state         <= ST_RUN;
            cfg.cfg_run_o <= 1'b1;
          end else cnt <= cnt - 1'b1;
`else
        ST_TMOD:
          if (cnt == '0) begin
            state         <= ST_RUN;
            cfg.cfg_run_o <= 1'b1;
          end else cnt <= cnt - 1'b1;
`endif
        ST_RUN: ;
        default: state <= ST_RST;
      endcase
    end
  end
endmodule
